// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with ghost rejection and press/release debounce.
// One key is tracked at a time; the scanned row is parked while that key is debounced and held.
module keypad_scan #(
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_tick,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
    localparam logic [3:0] TICKS = 4'(DEBOUNCE_TICKS);
    state_t     state;
    logic [3:0] sync1, sync2, cnt, cnt_inc;
    logic [1:0] row_idx, row_inc, col_idx, hit_col;
    logic       hit;
    // A single low column is a hit; none or several (ghosting) is ignored.
    always_comb begin
        hit = (sync2 == 4'b1110) || (sync2 == 4'b1101) || (sync2 == 4'b1011) || (sync2 == 4'b0111);
        hit_col = (sync2 == 4'b1101) ? 2'd1 : (sync2 == 4'b1011) ? 2'd2 : (sync2 == 4'b0111) ? 2'd3 : 2'd0;
        cnt_inc = cnt + 4'd1;
        row_inc = row_idx + 2'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 4'b1111;
            sync2     <= 4'b1111;
            state     <= SCAN;
            row_idx   <= 2'd0;
            row_n     <= 4'b1110;
            col_idx   <= 2'd0;
            cnt       <= 4'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            sync1     <= col_n;
            sync2     <= sync1;
            key_valid <= 1'b0;
            if (scan_tick) begin
                case (state)
                    SCAN: begin
                        if (hit) begin
                            col_idx <= hit_col;
                            cnt     <= 4'd0;
                            state   <= DEBOUNCE;
                        end else begin
                            row_idx <= row_inc;
                            row_n   <= ~(4'b0001 << row_inc);
                        end
                    end
                    DEBOUNCE: begin
                        if (hit && hit_col == col_idx) begin
                            if (cnt_inc == TICKS) begin
                                key_code  <= {row_idx, col_idx};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= 4'd0;
                                state     <= HELD;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            row_idx <= row_inc;
                            row_n   <= ~(4'b0001 << row_inc);
                            cnt     <= 4'd0;
                            state   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (&sync2) begin
                            if (cnt_inc == TICKS) begin
                                key_held <= 1'b0;
                                cnt      <= 4'd0;
                                row_idx  <= row_inc;
                                row_n    <= ~(4'b0001 << row_inc);
                                state    <= SCAN;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt <= 4'd0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed checks of scanning, debounce, ghost rejection and reset of keypad_scan.
// The keypad is modelled as one switch (key_row, key_col) plus an optional ghost pattern on row 1.
module tb_keypad_scan;
    logic       clk, rst, scan_tick;
    logic [3:0] col_n, row_n, key_code;
    logic       key_valid, key_held;
    logic       key_on, ghost;
    logic [1:0] key_row, key_col;
    logic [3:0] exp_row;
    int         vectors = 0, miscompares = 0, valid_cnt = 0;

    keypad_scan #(.DEBOUNCE_TICKS(3)) dut (
        .clk(clk), .rst(rst), .scan_tick(scan_tick), .col_n(col_n),
        .row_n(row_n), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col_n = 4'b1111;
        if (ghost && row_n == 4'b1101) col_n = 4'b0110;
        else if (key_on && !row_n[key_row]) col_n = ~(4'b0001 << key_col);
    end

    always @(posedge clk) if (key_valid) valid_cnt <= valid_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Columns settle well over 3 cycles before each tick; returns just after the tick edge.
    task automatic tick();
        repeat (4) @(negedge clk);
        scan_tick = 1'b1;
        @(negedge clk);
        scan_tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; scan_tick = 1'b0; key_on = 1'b0; ghost = 1'b0; key_row = 2'd0; key_col = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_row", row_n, 4'b1110);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_row = ~(4'b0001 << (i % 4));
            chk("idle_row", row_n, exp_row);
        end
        chk("idle_nvalid", valid_cnt, 0);
        key_on = 1'b1; key_row = 2'd2; key_col = 2'd1;
        tick(); chk("pre_row1", row_n, 4'b1101);
        tick(); chk("pre_row2", row_n, 4'b1011);
        tick(); chk("detect_row", row_n, 4'b1011);
        tick(); tick();
        chk("deb_held", key_held, 1'b0);
        chk("deb_nvalid", valid_cnt, 0);
        tick();
        chk("acc_valid", key_valid, 1'b1);
        chk("acc_code", key_code, 4'h9);
        chk("acc_held", key_held, 1'b1);
        @(negedge clk);
        chk("acc_pulse_end", key_valid, 1'b0);
        chk("acc_nvalid", valid_cnt, 1);
        tick(); tick();
        chk("hold_row", row_n, 4'b1011);
        chk("hold_held", key_held, 1'b1);
        key_on = 1'b0; tick(); tick();
        key_on = 1'b1; tick();
        key_on = 1'b0; tick(); tick();
        chk("rel_held_2", key_held, 1'b1);
        chk("rel_row_2", row_n, 4'b1011);
        tick();
        chk("rel_held", key_held, 1'b0);
        chk("rel_row", row_n, 4'b0111);
        key_on = 1'b1; key_row = 2'd0; key_col = 2'd2;
        tick(); chk("bnc_row0", row_n, 4'b1110);
        tick(); chk("bnc_detect", row_n, 4'b1110);
        key_on = 1'b0;
        tick();
        chk("bnc_row", row_n, 4'b1101);
        chk("bnc_code", key_code, 4'h9);
        chk("bnc_held", key_held, 1'b0);
        ghost = 1'b1;
        for (int i = 2; i <= 6; i++) begin
            tick();
            exp_row = ~(4'b0001 << (i % 4));
            chk("ghost_row", row_n, exp_row);
        end
        ghost = 1'b0;
        chk("bnc_ghost_nvalid", valid_cnt, 1);
        key_on = 1'b1; key_row = 2'd2; key_col = 2'd3;
        tick(); tick();
        chk("mid_deb_row", row_n, 4'b1011);
        rst = 1'b1; #1;
        chk("rdeb_row", row_n, 4'b1110);
        chk("rdeb_code", key_code, 4'h0);
        chk("rdeb_held", key_held, 1'b0);
        key_on = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        key_on = 1'b1; key_row = 2'd0; key_col = 2'd3;
        tick(); tick(); tick(); tick();
        chk("p2_code", key_code, 4'h3);
        chk("p2_held", key_held, 1'b1);
        @(negedge clk);
        rst = 1'b1; #1;
        chk("rheld_held", key_held, 1'b0);
        chk("rheld_code", key_code, 4'h0);
        chk("rheld_row", row_n, 4'b1110);
        chk("rheld_valid", key_valid, 1'b0);
        key_on = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick(); tick();
        chk("end_valid", key_valid, 1'b0);
        chk("end_nvalid", valid_cnt, 2);
        chk("end_row", row_n, 4'b1011);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

4x4 matrix keypad scanner and debouncer for the calculator's key entry. It consumes the 1 kHz scan strobe produced by the clock-divider block, drives the keypad rows and samples the columns. For each debounced press it emits a 4-bit key code, a single-cycle valid pulse and a held level. The arithmetic/control FSM reads it downstream.

## Interface
- DEBOUNCE_TICKS, 3: consecutive matching strobe samples required to accept a press or a release; legal range 1..15.
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- scan_tick  input  1  one-clk-cycle enable strobe, nominally 1 kHz, synchronous to clk.
- col_n  input  4  keypad columns, active-low, externally pulled up; bit i = column i; asynchronous to clk.
- row_n  output  4  keypad row drive, active-low, exactly one bit low at all times.
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key.
- key_valid  output  1  one-clk-cycle pulse on acceptance of a press.
- key_held  output  1  high from acceptance until the release is accepted.

## Operation
- col_n passes through a 2-flop synchronizer (reset value 4'b1111). All decisions use the synchronized value, sampled only in cycles with scan_tick=1.
- "Single hit": the sample has exactly one bit low; col_idx = index of that bit. Zero or ≥2 bits low is "no hit" (ghost rejection).
- row_n = ~(4'b0001 << row_idx). row_idx is a 2-bit counter that wraps 3→0.
- State SCAN, on a tick:
  - Single hit: latch row_idx and col_idx, clear cnt, go to DEBOUNCE.
  - Otherwise: row_idx += 1.
- State DEBOUNCE (row held), on a tick:
  - Sample is a single hit on the latched column: cnt += 1.
  - Anything else: go to SCAN, row_idx += 1, cnt = 0, no output change.
  - When cnt reaches DEBOUNCE_TICKS: load key_code, pulse key_valid, set key_held, clear cnt, go to HELD.
- State HELD (row held), on a tick:
  - All columns high: cnt += 1.
  - Any bit low: cnt = 0.
  - When cnt reaches DEBOUNCE_TICKS: clear key_held, clear cnt, row_idx += 1, go to SCAN.
- A second key pressed while in HELD is ignored until the first is released.
- key_code holds its value until the next accepted press.
- cnt width is 4 bits, which covers the full parameter range; it never exceeds DEBOUNCE_TICKS.
- scan_tick stuck high: every cycle is treated as a tick; behaviour is otherwise unchanged.
- Reset (asynchronous, at any time, including mid-DEBOUNCE or HELD):
  - state = SCAN, row_idx = 0, row_n = 4'b1110, cnt = 0.
  - key_code = 4'h0, key_valid = 0, key_held = 0, synchronizer = 4'b1111.
  - No key_valid pulse is produced by reset or by its release.

## Timing
- All outputs are registered; every change appears the cycle after the scan_tick cycle that caused it.
- Column-to-decision latency is 2 clk cycles. col_n must be stable ≥3 clk cycles before a tick to be seen at that tick.
- Row drive changes the cycle after a tick. The columns then have a full tick period to settle.
- Press acceptance takes 1 + DEBOUNCE_TICKS ticks from first detection. key_valid is high for exactly one clk cycle in the cycle after the accepting tick.
- Release acceptance takes DEBOUNCE_TICKS ticks of all-high columns. key_held falls in the same cycle that row_n advances.
- Worst-case detection of a new press is 4 + DEBOUNCE_TICKS ticks (one full row sweep plus debounce).

## Test plan
- Reset, no keys, 8 ticks:
  - All outputs at reset values.
  - row_n sequence 1110, 1101, 1011, 0111, 1110, ...
  - key_valid never asserts.
- Press row 2 / col 1 (DEBOUNCE_TICKS=3; col_n=4'b1101 whenever row_n=1011):
  - First detection when row_n=1011; 3 further ticks follow.
  - Then key_valid pulses for 1 cycle, key_code=4'h9, key_held=1.
  - row_n stays 1011 while held.
- Bounce: col low at the detection tick, high at the next tick:
  - No key_valid, key_code unchanged.
  - Returns to SCAN and row_n advances to the next row.
- Release after hold: columns high for 2 ticks, low for 1, then high for 3:
  - key_held falls only after the final 3rd high tick.
  - row_n advances in the same cycle.
- Ghost: row 1 active with col_n=4'b0110 (two columns low):
  - No detection; scanning continues every tick.
- Reset asserted mid-DEBOUNCE and mid-HELD:
  - Immediate return to the reset values.
  - No key_valid pulse; key_held=0.
